// File: rtl/mass_start_dispatch.sv
// -----------------------------------------------------------------------------
// mass_start_dispatch
//
// Initiator side of the per-layer start/done handshake. A single go request
// launches a one-cycle start pulse to every enabled unit. Each unit's
// completion is collected into sticky flags. One done pulse is issued once
// every enabled unit has reported.
//
// Optional feature: define MASS_DISPATCH_TIMEOUT_EN to add a watchdog that
// ends the round after TIMEOUT_CYCLES WAIT cycles and flags it on timeout_o.
//
// Parameters
//   NUM_UNITS       number of dispatched units (>= 1)
//   TIMEOUT_CYCLES  watchdog limit in WAIT cycles (watchdog build only)
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   rst_i        synchronous, active-high reset
//   go_i         request a dispatch round; sampled only in IDLE
//   unit_mask_i  units taking part; latched when go_i is accepted
//   unit_done_i  per-unit completion (pulse or level), captured sticky
//   start_o      one-cycle start pulse per enabled unit
//   busy_o       high from the LAUNCH cycle through the FINISH cycle
//   done_o       one-cycle pulse, round complete
//   done_vec_o   captured done flags, held until the next accepted go
//   timeout_o    one-cycle pulse with done_o when the watchdog fired
// -----------------------------------------------------------------------------
module mass_start_dispatch #(
    parameter int NUM_UNITS      = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 go_i,
    input  logic [NUM_UNITS-1:0] unit_mask_i,
    input  logic [NUM_UNITS-1:0] unit_done_i,
    output logic [NUM_UNITS-1:0] start_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [NUM_UNITS-1:0] done_vec_o,
    output logic                 timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FINISH
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_UNITS-1:0] mask_q, mask_d;
    logic [NUM_UNITS-1:0] done_vec_q, done_vec_d;
    logic                 timeout_q, timeout_d;
    logic [NUM_UNITS-1:0] captured;
    logic                 complete;

    // Flags as they will be after this edge; unmasked units never gain credit.
    assign captured = done_vec_q | (unit_done_i & mask_q);
    assign complete = ((captured & mask_q) == mask_q);

`ifdef MASS_DISPATCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wdog_q, wdog_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned, which would infer a latch.
        state_d    = state_q;
        mask_d     = mask_q;
        done_vec_d = done_vec_q;
        timeout_d  = 1'b0;
`ifdef MASS_DISPATCH_TIMEOUT_EN
        wdog_d     = wdog_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (go_i) begin
                    mask_d     = unit_mask_i;
                    // Clearing on accept also gives an empty round done_vec=0.
                    done_vec_d = '0;
                    state_d    = (unit_mask_i != '0) ? S_LAUNCH : S_FINISH;
                end
            end
            S_LAUNCH: begin
                // Units may already report while start is on the wire.
                done_vec_d = captured;
`ifdef MASS_DISPATCH_TIMEOUT_EN
                wdog_d     = '0;
`endif
                state_d    = complete ? S_FINISH : S_WAIT;
            end
            S_WAIT: begin
                done_vec_d = captured;
                if (complete) begin
                    // Completion wins over an expiry on the same edge.
                    state_d = S_FINISH;
                end
`ifdef MASS_DISPATCH_TIMEOUT_EN
                else if (wdog_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = S_FINISH;
                    timeout_d = 1'b1;
                end
                wdog_d = wdog_q + 1'b1;
`endif
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst_i) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            done_vec_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            done_vec_q <= done_vec_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef MASS_DISPATCH_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    // All outputs decode straight from registers.
    assign start_o    = (state_q == S_LAUNCH) ? mask_q : '0;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_FINISH);
    assign done_vec_o = done_vec_q;
    assign timeout_o  = timeout_q;

endmodule
